// File: rtl/pipelined_shifter.sv
// Fully pipelined barrel shifter/rotator: stage k shifts or rotates by 2^k when
// shamt bit k is set, with valid/ready flow control and bubble collapsing.
module pipelined_shifter #(
   parameter  int WIDTH = 32,
   parameter  int TAG_W = 4,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   in_shamt,
   input  logic [2:0]       in_op,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_carry,
   output logic             out_zero,
   output logic [TAG_W-1:0] out_tag
);

   typedef enum logic [2:0] {
      OP_SLL = 3'b000,
      OP_SRL = 3'b001,
      OP_SRA = 3'b010,
      OP_ROL = 3'b011,
      OP_ROR = 3'b100
   } op_e;

   logic [SHW-1:0] vld;
   logic [SHW-1:0] en;

   // en[k]: stage k loads this cycle, either because it is empty or its content moves on.
   always_comb begin : flow
      logic downstream_ok;
      // NOTE: blocking assignments in always_comb; the chain is evaluated in order, output to input.
      en            = '0;
      downstream_ok = out_ready;
      for (int k = SHW - 1; k >= 0; k--) begin
         en[k]         = !vld[k] || downstream_ok;
         downstream_ok = en[k];
      end
   end

   for (genvar k = 0; k < SHW; k++) begin : g_stage
      localparam int AMT = 1 << k;

      logic             src_vld;
      logic [WIDTH-1:0] src_data;
      logic [SHW-1:k]   src_sh;
      logic [2:0]       src_op;
      logic [TAG_W-1:0] src_tag;
      logic             src_carry;
      logic [WIDTH-1:0] nxt_data;
      logic             nxt_carry;
      logic             v_q;
      logic [WIDTH-1:0] data_q;
      logic [TAG_W-1:0] tag_q;
      logic             carry_q;

      if (k == 0) begin : g_src
         assign src_vld   = in_valid;
         assign src_data  = in_data;
         assign src_sh    = in_shamt;
         assign src_op    = in_op;
         assign src_tag   = in_tag;
         assign src_carry = 1'b0;
      end else begin : g_src
         assign src_vld   = g_stage[k-1].v_q;
         assign src_data  = g_stage[k-1].data_q;
         assign src_sh    = g_stage[k-1].g_ctl.sh_q;
         assign src_op    = g_stage[k-1].g_ctl.op_q;
         assign src_tag   = g_stage[k-1].tag_q;
         assign src_carry = g_stage[k-1].carry_q;
      end

      // Carry is the last bit moved out by the most recent active stage; inactive stages pass it on.
      always_comb begin
         nxt_data  = src_data;
         nxt_carry = src_carry;
         if (src_sh[k]) begin
            case (src_op)
               OP_SLL: begin
                  nxt_data  = src_data << AMT;
                  nxt_carry = src_data[WIDTH-AMT];
               end
               OP_SRL: begin
                  nxt_data  = src_data >> AMT;
                  nxt_carry = src_data[AMT-1];
               end
               OP_SRA: begin
                  nxt_data  = $signed(src_data) >>> AMT;
                  nxt_carry = src_data[AMT-1];
               end
               OP_ROL: begin
                  nxt_data  = (src_data << AMT) | (src_data >> (WIDTH - AMT));
                  nxt_carry = src_data[WIDTH-AMT];
               end
               OP_ROR: begin
                  nxt_data  = (src_data >> AMT) | (src_data << (WIDTH - AMT));
                  nxt_carry = src_data[AMT-1];
               end
               default: ;
            endcase
         end
      end

      always_ff @(posedge clk) begin
         // NOTE: non-blocking assignments for every registered field.
         if (rst) begin
            v_q     <= 1'b0;
            data_q  <= '0;
            tag_q   <= '0;
            carry_q <= 1'b0;
         end else if (en[k]) begin
            v_q <= src_vld;
            if (src_vld) begin
               data_q  <= nxt_data;
               tag_q   <= src_tag;
               carry_q <= nxt_carry;
            end
         end
      end

      assign vld[k] = v_q;

      if (k < SHW - 1) begin : g_ctl
         logic [SHW-1:k+1] sh_q;
         logic [2:0]       op_q;

         always_ff @(posedge clk) begin
            if (rst) begin
               sh_q <= '0;
               op_q <= '0;
            end else if (en[k] && src_vld) begin
               sh_q <= src_sh[SHW-1:k+1];
               op_q <= src_op;
            end
         end
      end else begin : g_zero
         logic zero_q;

         always_ff @(posedge clk) begin
            if (rst) begin
               zero_q <= 1'b0;
            end else if (en[k] && src_vld) begin
               zero_q <= (nxt_data == '0);
            end
         end
      end
   end

   assign in_ready  = en[0];
   assign out_valid = vld[SHW-1];
   assign out_data  = g_stage[SHW-1].data_q;
   assign out_carry = g_stage[SHW-1].carry_q;
   assign out_tag   = g_stage[SHW-1].tag_q;
   assign out_zero  = g_stage[SHW-1].g_zero.zero_q;

endmodule

// File: doc/pipelined_shifter.md
Name: pipelined_shifter

Overview:
- Parametrised, fully pipelined barrel shifter/rotator for the pRISC ALU datapath.
- Generalises the 32-bit combinational logical/arithmetic shifter: any power-of-two WIDTH, adds rotate modes, carry-out and zero flags, a sideband tag, and valid/ready flow control with backpressure.
- One mux level per pipeline stage. Sustains one operation per cycle.

Parameters:
- WIDTH, 32, data width; power of two, minimum 4. Derived localparam SHW = log2(WIDTH) gives both the shamt width and the pipeline depth.
- TAG_W, 4, width of the opaque tag carried alongside each operation (e.g. destination register id).

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input operation valid
- in_ready  out  1  block can accept an operation this cycle
- in_data  in  WIDTH  operand
- in_shamt  in  SHW  shift amount, 0..WIDTH-1
- in_op  in  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR; 101-111 reserved
- in_tag  in  TAG_W  sideband tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_data  out  WIDTH  result
- out_carry  out  1  last bit shifted out (see rules)
- out_zero  out  1  out_data == 0
- out_tag  out  TAG_W  tag of this result

Behaviour:
- Reset: one clk is synchronous and rst is synchronous active-high. All stage valid bits clear. out_valid=0, out_data=0, out_carry=0, out_zero=0, out_tag=0. in_ready=1 from the first cycle after reset deasserts.
- Transfer rules:
  - Input transfers when in_valid && in_ready.
  - Output transfers when out_valid && out_ready.
- Pipeline structure:
  - SHW register stages. Stage k (0..SHW-1) applies a shift/rotate by 2^k when shamt bit k is 1.
  - Each stage holds data, shamt, op, tag, carry and a valid bit.
  - Stage SHW-1 is the output register.
- Latency: a result is visible SHW cycles after acceptance (5 for WIDTH=32) when there is no stall.
- Flow control:
  - adv[SHW-1] = !out_valid || out_ready.
  - adv[k] = !valid[k+1] || adv[k+1].
  - in_ready = !valid[0] || adv[0]. This is combinational, and in_ready does not depend on in_valid.
  - Bubbles collapse: an empty stage accepts even when downstream is stalled.
  - A stalled stage holds all of its fields unchanged.
  - Operations never drop, duplicate or reorder.
- Fill semantics:
  - SLL: zero fill.
  - SRL: zero fill.
  - SRA: sign fill from operand bit WIDTH-1.
  - ROL/ROR: circular.
  - Reserved op: out_data = in_data, out_carry = 0.
- Carry rules (s = shamt, a = operand):
  - s == 0: carry = 0 for every op.
  - SLL: carry = a[WIDTH-s].
  - SRL and SRA: carry = a[s-1].
  - ROL: carry = out_data[0].
  - ROR: carry = out_data[WIDTH-1].
- out_zero: computed from the final data and registered together with out_data.
- Boundaries:
  - shamt = WIDTH-1 is legal.
  - SRA of a negative value by WIDTH-1 gives all ones.
  - Simultaneous input accept and output drain in the same cycle is legal; occupancy stays constant.
- Reset mid-operation: all in-flight operations are discarded. out_valid=0 the cycle after rst is sampled, and no partial result ever appears.
- Outputs are registered only; there is no combinational path from in_* to out_*.

Test Plan:
- Reset/idle: assert rst 2 cycles with in_valid=1 -> out_valid=0 and all outputs 0; after release, in_ready=1.
- Directed ops, WIDTH=32, out_ready=1:
  - SLL 0x00000001 s=31 -> 0x80000000, carry 0.
  - SRL 0x80000001 s=1 -> 0x40000000, carry 1.
  - SRA 0x80000000 s=4 -> 0xF8000000, carry 0.
  - ROL 0x80000001 s=1 -> 0x00000003, carry 1.
  - ROR 0x000000F1 s=4 -> 0x1000000F, carry 0.
  - SRL 0x00000001 s=1 -> 0x00000000, zero 1, carry 1.
  - Each result appears exactly 5 cycles after accept.
- Throughput: 8 back-to-back ops with tags 0..7 -> out_valid high for 8 consecutive cycles starting 5 cycles after the first accept; tags emerge in order 0..7.
- Backpressure: fill the pipe, then hold out_ready=0 for 3 cycles -> in_ready=0 once full, out_data/out_tag stable throughout; on release, all results drain in order with none lost.
- Bubble collapse: one op accepted, then out_ready=0 -> in_ready stays 1 until 5 ops are held; the 6th in_valid sees in_ready=0.
- Mid-flight reset: 3 ops in flight, assert rst for 1 cycle -> out_valid=0 the next cycle and none of the 3 results ever appears.
